// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - shared word map, defaults and helpers for the IO register block
package io_map_pkg;

    localparam int IDX_LED = 0;
    localparam int IDX_SW  = 1;
    localparam int IDX_CNT = 2;

    localparam int          N_WORDS_DEF   = 4;
    localparam int          ADR_LSB_DEF   = 2;
    localparam logic [31:0] LED_RESET_DEF = 32'h80000001;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFFFFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/io_change_counter.sv
// rtl/io_change_counter.sv - saturating switch-change counter with read-to-clear
module io_change_counter
    import io_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    // A clear that coincides with an increment keeps the new event, so it restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? 32'd1 : 32'd0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/io_mem_responder.sv
// rtl/io_mem_responder.sv - dual-port IO word bank: device port plus CPU valid/ready port
module io_mem_responder
    import io_map_pkg::*;
#(
    parameter int          N_WORDS   = N_WORDS_DEF,
    parameter logic [31:0] LED_RESET = LED_RESET_DEF,
    parameter int          ADR_LSB   = ADR_LSB_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dev_adr,
    input  logic        dev_we,
    input  logic [31:0] dev_wdata,
    output logic [31:0] dev_rdata,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_rsp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rsp_err
);

    localparam int IDX_W = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] I_SW  = IDX_W'(IDX_SW);
    localparam logic [IDX_W-1:0] I_CNT = IDX_W'(IDX_CNT);

    logic [31:0]      words [N_WORDS];
    logic [31:0]      cnt;
    logic [31:0]      dev_word;
    logic [31:0]      cpu_word;
    logic [IDX_W-1:0] dev_idx;
    logic [IDX_W-1:0] cpu_idx;
    logic             dev_hit;
    logic             cpu_hit;
    logic             dev_wr;
    logic             cpu_accept;
    logic             cpu_wr;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [31:0]      dev_rd_word;
    logic [31:0]      cpu_rd_word;
    logic             rsp_valid_q;
    logic             unused_adr_bits;

    // Range check uses the whole word address so high address bits cannot alias.
    assign dev_word = 32'(dev_adr[31:ADR_LSB]);
    assign cpu_word = 32'(cpu_adr[31:ADR_LSB]);
    assign dev_idx  = dev_word[IDX_W-1:0];
    assign cpu_idx  = cpu_word[IDX_W-1:0];
    assign dev_hit  = dev_word < 32'(N_WORDS);
    assign cpu_hit  = cpu_word < 32'(N_WORDS);
    assign unused_adr_bits = ^{dev_adr[ADR_LSB-1:0], cpu_adr[ADR_LSB-1:0]};

    assign cpu_req_ready = !(dev_we && cpu_req_valid && cpu_we && dev_word == cpu_word);
    assign cpu_accept    = cpu_req_valid && cpu_req_ready;

    assign dev_wr = dev_we && dev_hit && dev_idx != I_CNT;
    assign cpu_wr = cpu_accept && cpu_we && cpu_hit && cpu_idx != I_CNT;

    assign cnt_inc = dev_wr && dev_idx == I_SW && dev_wdata != words[I_SW];
    assign cnt_clr = cpu_accept && !cpu_we && cpu_hit && cpu_idx == I_CNT;

    io_change_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (cnt)
    );

    always_comb begin
        dev_rd_word = '0;
        if (dev_hit) begin
            dev_rd_word = (dev_idx == I_CNT) ? cnt : words[dev_idx];
        end
    end

    always_comb begin
        cpu_rd_word = '0;
        if (cpu_hit) begin
            cpu_rd_word = (cpu_idx == I_CNT) ? cnt : words[cpu_idx];
        end
    end

    // Same-word device/CPU writes never coincide: the CPU is stalled by cpu_req_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_WORDS; i++) begin
                words[i] <= (i == IDX_LED) ? LED_RESET : 32'd0;
            end
        end else begin
            if (dev_wr) begin
                words[dev_idx] <= dev_wdata;
            end
            if (cpu_wr) begin
                words[cpu_idx] <= cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dev_rdata   <= '0;
            rsp_valid_q <= 1'b0;
            cpu_rdata   <= '0;
            cpu_rsp_err <= 1'b0;
        end else begin
            dev_rdata   <= dev_rd_word;
            rsp_valid_q <= cpu_accept;
            if (cpu_accept) begin
                cpu_rdata   <= cpu_we ? 32'd0 : cpu_rd_word;
                cpu_rsp_err <= !cpu_hit;
            end
        end
    end

    // A response still in flight when reset rises is suppressed immediately.
    assign cpu_rsp_valid = rsp_valid_q && !reset;

endmodule

// File: tb/tb_io_mem_responder.sv
// tb/tb_io_mem_responder.sv - directed self-checking bench for io_mem_responder
module tb_io_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dev_adr;
    logic        dev_we;
    logic [31:0] dev_wdata;
    logic [31:0] dev_rdata;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_rsp_err;

    int checks   = 0;
    int failures = 0;

    io_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .dev_adr       (dev_adr),
        .dev_we        (dev_we),
        .dev_wdata     (dev_wdata),
        .dev_rdata     (dev_rdata),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_we        (cpu_we),
        .cpu_adr       (cpu_adr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rdata     (cpu_rdata),
        .cpu_rsp_err   (cpu_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dev_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        dev_adr = adr;
        dev_we  = 1'b0;
        tick();
        check_eq(tag, dev_rdata, exp);
    endtask

    task automatic dev_write(input logic [31:0] adr, input logic [31:0] data);
        dev_adr   = adr;
        dev_we    = 1'b1;
        dev_wdata = data;
        tick();
        dev_we    = 1'b0;
    endtask

    task automatic cpu_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input logic exp_err);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_adr       = adr;
        cpu_wdata     = wdata;
        #1;
        check_eq({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
        tick();
        cpu_req_valid = 1'b0;
        check_eq({tag, "_valid"}, 32'(cpu_rsp_valid), 32'd1);
        check_eq({tag, "_rdata"}, cpu_rdata, exp_rdata);
        check_eq({tag, "_err"}, 32'(cpu_rsp_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        dev_adr = '0; dev_we = 1'b0; dev_wdata = '0;
        cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        tick();
        check_eq("rst_valid_c1", 32'(cpu_rsp_valid), 32'd0);
        check_eq("rst_dev_rdata", dev_rdata, 32'd0);
        tick();
        check_eq("rst_valid_c2", 32'(cpu_rsp_valid), 32'd0);
        reset = 1'b0;

        dev_read("rst_led", 32'h0, 32'h80000001);
        cpu_txn("rst_sw", 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        cpu_txn("rst_cnt", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        tick();
        check_eq("rsp_pulse_once", 32'(cpu_rsp_valid), 32'd0);

        cpu_txn("cpu_wr_led", 1'b1, 32'h0, 32'h000003FF, 32'h0, 1'b0);
        dev_read("dev_rd_led", 32'h0, 32'h000003FF);

        // counter: 0 -> 5 (change) -> 5 (same, no count) -> A (change) = 2
        dev_write(32'h4, 32'h005);
        dev_write(32'h4, 32'h005);
        dev_write(32'h4, 32'h00A);
        cpu_txn("cnt_rd1", 1'b0, 32'h8, 32'h0, 32'd2, 1'b0);
        cpu_txn("cnt_rd2", 1'b0, 32'h8, 32'h0, 32'd0, 1'b0);
        cpu_txn("sw_rd", 1'b0, 32'h4, 32'h0, 32'h00A, 1'b0);

        // collision on word0: device wins, CPU write lands one cycle later
        dev_adr = 32'h0; dev_we = 1'b1; dev_wdata = 32'h1;
        cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0; cpu_wdata = 32'h2;
        #1;
        check_eq("coll_ready_lo", 32'(cpu_req_ready), 32'd0);
        tick();
        check_eq("coll_no_rsp", 32'(cpu_rsp_valid), 32'd0);
        dev_we = 1'b0;
        #1;
        check_eq("coll_ready_hi", 32'(cpu_req_ready), 32'd1);
        tick();
        cpu_req_valid = 1'b0;
        check_eq("coll_valid", 32'(cpu_rsp_valid), 32'd1);
        check_eq("coll_err", 32'(cpu_rsp_err), 32'd0);
        dev_read("coll_final", 32'h0, 32'h2);

        // device read returns the pre-write value of the same edge
        dev_adr = 32'h4; dev_we = 1'b1; dev_wdata = 32'h7;
        tick();
        dev_we = 1'b0;
        check_eq("dev_prewrite", dev_rdata, 32'h00A);

        // device read of word0 while the CPU writes it: old value, then new
        dev_adr = 32'h0;
        cpu_txn("cpu_wr_55", 1'b1, 32'h0, 32'h55, 32'h0, 1'b0);
        check_eq("same_cyc_old", dev_rdata, 32'h2);
        dev_read("same_cyc_new", 32'h0, 32'h55);

        // counter is 1 after the 0xA->0x7 write; four more changes make 5
        dev_write(32'h4, 32'h8);
        dev_write(32'h4, 32'h9);
        dev_write(32'h4, 32'h7);
        dev_write(32'h4, 32'h8);
        dev_adr = 32'h4; dev_we = 1'b1; dev_wdata = 32'h9;
        cpu_txn("clr_inc_old", 1'b0, 32'h8, 32'h0, 32'd5, 1'b0);
        dev_we = 1'b0;
        cpu_txn("clr_inc_new", 1'b0, 32'h8, 32'h0, 32'd1, 1'b0);

        cpu_txn("cnt_wr_ign", 1'b1, 32'h8, 32'h77, 32'h0, 1'b0);
        cpu_txn("cnt_after_wr", 1'b0, 32'h8, 32'h0, 32'd0, 1'b0);
        cpu_txn("cpu_wr_sw", 1'b1, 32'h4, 32'h123, 32'h0, 1'b0);
        cpu_txn("cnt_cpu_sw", 1'b0, 32'h8, 32'h0, 32'd0, 1'b0);

        cpu_txn("oor_rd", 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        cpu_txn("oor_wr", 1'b1, 32'h40, 32'hDEAD, 32'h0, 1'b1);
        dev_write(32'h40, 32'hBEEF);
        dev_read("oor_dev_rd", 32'h40, 32'h0);
        cpu_txn("scr_rd0", 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        cpu_txn("scr_wr", 1'b1, 32'hC, 32'h1234, 32'h0, 1'b0);
        dev_read("scr_dev_rd", 32'hC, 32'h1234);

        // accept a read, then reset: its response must never appear
        cpu_req_valid = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0;
        tick();
        cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h0; cpu_wdata = 32'hBEEF;
        dev_adr = 32'hC; dev_we = 1'b1; dev_wdata = 32'h99;
        reset = 1'b1;
        #1;
        check_eq("midrst_drop1", 32'(cpu_rsp_valid), 32'd0);
        tick();
        check_eq("midrst_drop2", 32'(cpu_rsp_valid), 32'd0);
        cpu_req_valid = 1'b0; dev_we = 1'b0;
        reset = 1'b0;
        dev_read("midrst_led", 32'h0, 32'h80000001);
        dev_read("midrst_scr", 32'hC, 32'h0);
        check_eq("midrst_quiet", 32'(cpu_rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
